// File: rtl/pulse_stretch.sv
// Stretches a 1-cycle event tick into a visible pulse of 2^N-1 cycles followed by a
// 2^G-1 cycle low gap. Define PULSE_STRETCH_RETRIG_EN to make ticks extend the pulse.
module pulse_stretch #(
    parameter int unsigned N = 21,
    parameter int unsigned G = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_in,
    output logic pulse_out,
    output logic busy,
    output logic done_tick
);

    localparam int unsigned W = (N > G) ? N : G;

    localparam logic [W-1:0] HoldLoad = W'({N{1'b1}});
    localparam logic [W-1:0] GapLoad  = W'({G{1'b1}});
    localparam logic [W-1:0] CntOne   = W'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StGap  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   q_dec;
    logic           last;

`ifndef PULSE_STRETCH_RETRIG_EN
    logic           pending_q, pending_d;
`endif

    // Zero-count guard: the counter never wraps, and a stray zero still terminates a phase.
    assign q_dec = (q_q != '0) ? (q_q - CntOne) : '0;
    assign last  = (q_q <= CntOne);

`ifdef PULSE_STRETCH_RETRIG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        pulse_out = 1'b0;
        busy      = 1'b0;
        done_tick = 1'b0;
        case (state_q)
            StIdle: begin
                q_d = '0;
                if (tick_in) begin
                    state_d = StHold;
                    q_d     = HoldLoad;
                end
            end
            StHold: begin
                pulse_out = 1'b1;
                busy      = 1'b1;
                done_tick = last;
                if (tick_in) begin
                    q_d = HoldLoad;
                end else if (last) begin
                    state_d = StGap;
                    q_d     = GapLoad;
                end else begin
                    q_d = q_dec;
                end
            end
            StGap: begin
                busy = 1'b1;
                if (tick_in) begin
                    state_d = StHold;
                    q_d     = HoldLoad;
                end else if (last) begin
                    state_d = StIdle;
                    q_d     = '0;
                end else begin
                    q_d = q_dec;
                end
            end
            default: begin
                state_d = StIdle;
                q_d     = '0;
            end
        endcase
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            q_q       <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        pending_d = pending_q;
        pulse_out = 1'b0;
        busy      = 1'b0;
        done_tick = 1'b0;
        case (state_q)
            StIdle: begin
                q_d       = '0;
                pending_d = 1'b0;
                if (tick_in) begin
                    state_d = StHold;
                    q_d     = HoldLoad;
                end
            end
            StHold: begin
                pulse_out = 1'b1;
                busy      = 1'b1;
                done_tick = last;
                if (tick_in) begin
                    pending_d = 1'b1;
                end
                if (last) begin
                    state_d = StGap;
                    q_d     = GapLoad;
                end else begin
                    q_d = q_dec;
                end
            end
            StGap: begin
                busy = 1'b1;
                if (last) begin
                    // A tick arriving on the final gap cycle is served directly.
                    pending_d = 1'b0;
                    if (pending_q || tick_in) begin
                        state_d = StHold;
                        q_d     = HoldLoad;
                    end else begin
                        state_d = StIdle;
                        q_d     = '0;
                    end
                end else begin
                    q_d = q_dec;
                    if (tick_in) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                q_d       = '0;
                pending_d = 1'b0;
            end
        endcase
    end
`endif

endmodule
